// File: rtl/bouncing_sprite.sv
// bouncing_sprite: draws a SPRITE_W x SPRITE_H block in raster order. It then
// holds the block for one frame, erases it in the background colour, moves it
// according to iMode with a clamp-and-reverse bounce at the limits, and
// repeats for as long as iEnable is high at the end of each frame.
module bouncing_sprite #(
   parameter int unsigned SPRITE_W    = 15,
   parameter int unsigned SPRITE_H    = 15,
   parameter int unsigned X_MIN       = 0,
   parameter int unsigned X_MAX       = 145,
   parameter int unsigned Y_MIN       = 68,
   parameter int unsigned Y_MAX       = 100,
   parameter int unsigned X_START     = 72,
   parameter int unsigned Y_START     = 80,
   parameter int unsigned STEP        = 1,
   parameter int unsigned FRAME_TICKS = 50000000,
   parameter logic [2:0]  BG_COLOUR   = 3'd0
) (
   input  logic       iClock,
   input  logic       iResetn,
   input  logic       iEnable,
   input  logic [1:0] iMode,
   input  logic [2:0] iColour,
   output logic [7:0] oX,
   output logic [6:0] oY,
   output logic [2:0] oColour,
   output logic       oPlot,
   output logic       oFrameDone
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRAW,
      ST_WAIT,
      ST_ERASE,
      ST_MOVE
   } state_t;

   localparam logic [4:0]  CX_LAST    = 5'(SPRITE_W - 1);
   localparam logic [4:0]  CY_LAST    = 5'(SPRITE_H - 1);
   localparam logic [31:0] FRAME_LOAD = 32'(FRAME_TICKS - 1);
   localparam logic [8:0]  STEP9      = 9'(STEP);
   localparam logic [8:0]  X_MIN9     = 9'(X_MIN);
   localparam logic [8:0]  X_MAX9     = 9'(X_MAX);
   localparam logic [8:0]  Y_MIN9     = 9'(Y_MIN);
   localparam logic [8:0]  Y_MAX9     = 9'(Y_MAX);
   localparam logic [7:0]  X_MIN8     = 8'(X_MIN);
   localparam logic [7:0]  X_MAX8     = 8'(X_MAX);
   localparam logic [7:0]  X_START8   = 8'(X_START);
   localparam logic [7:0]  STEP8      = 8'(STEP);
   localparam logic [6:0]  Y_MIN7     = 7'(Y_MIN);
   localparam logic [6:0]  Y_MAX7     = 7'(Y_MAX);
   localparam logic [6:0]  Y_START7   = 7'(Y_START);
   localparam logic [6:0]  STEP7      = 7'(STEP);

   state_t      state;
   logic [7:0]  pos_x;
   logic [6:0]  pos_y;
   logic        dir_x;
   logic        dir_y;
   logic [4:0]  cx;
   logic [4:0]  cy;
   logic [31:0] frame_cnt;
   logic [2:0]  colour_q;

   logic [8:0]  x_up;
   logic [8:0]  y_up;
   logic [7:0]  next_x;
   logic [6:0]  next_y;
   logic        next_dir_x;
   logic        next_dir_y;
   logic        scan_last;

   // Bounce candidates for both axes; MOVE applies only the axes iMode selects.
   // Comparisons are done 9 bits wide so pos+STEP and pos-STEP never wrap.
   always_comb begin
      x_up       = {1'b0, pos_x} + STEP9;
      y_up       = {2'b00, pos_y} + STEP9;
      next_x     = pos_x;
      next_dir_x = dir_x;
      next_y     = pos_y;
      next_dir_y = dir_y;
      if (!dir_x) begin
         if (x_up > X_MAX9) begin
            next_x     = X_MAX8;
            next_dir_x = 1'b1;
         end else begin
            next_x = x_up[7:0];
         end
      end else if ({1'b0, pos_x} < X_MIN9 + STEP9) begin
         next_x     = X_MIN8;
         next_dir_x = 1'b0;
      end else begin
         next_x = pos_x - STEP8;
      end
      if (!dir_y) begin
         if (y_up > Y_MAX9) begin
            next_y     = Y_MAX7;
            next_dir_y = 1'b1;
         end else begin
            next_y = y_up[6:0];
         end
      end else if ({2'b00, pos_y} < Y_MIN9 + STEP9) begin
         next_y     = Y_MIN7;
         next_dir_y = 1'b0;
      end else begin
         next_y = pos_y - STEP7;
      end
   end

   // Final pixel of the raster scan.
   always_comb begin
      scan_last = (cx == CX_LAST) && (cy == CY_LAST);
   end

   // Sprite sequencer: state, scan counters, frame timer, position and
   // registered pixel outputs.
   always_ff @(posedge iClock or negedge iResetn) begin
      if (!iResetn) begin
         state      <= ST_IDLE;
         pos_x      <= X_START8;
         pos_y      <= Y_START7;
         dir_x      <= 1'b0;
         dir_y      <= 1'b0;
         cx         <= '0;
         cy         <= '0;
         frame_cnt  <= '0;
         colour_q   <= '0;
         oX         <= '0;
         oY         <= '0;
         oColour    <= '0;
         oPlot      <= 1'b0;
         oFrameDone <= 1'b0;
      end else begin
         oPlot      <= 1'b0;
         oFrameDone <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (iEnable) begin
                  state    <= ST_DRAW;
                  colour_q <= iColour;
                  cx       <= '0;
                  cy       <= '0;
               end
            end
            ST_DRAW, ST_ERASE: begin
               oPlot   <= 1'b1;
               oX      <= pos_x + {3'b000, cx};
               oY      <= pos_y + {2'b00, cy};
               oColour <= (state == ST_DRAW) ? colour_q : BG_COLOUR;
               if (scan_last) begin
                  cx <= '0;
                  cy <= '0;
                  if (state == ST_DRAW) begin
                     state      <= ST_WAIT;
                     frame_cnt  <= FRAME_LOAD;
                     oFrameDone <= 1'b1;
                  end else begin
                     state <= ST_MOVE;
                  end
               end else if (cx == CX_LAST) begin
                  cx <= '0;
                  cy <= cy + 5'd1;
               end else begin
                  cx <= cx + 5'd1;
               end
            end
            ST_WAIT: begin
               if (frame_cnt == '0) begin
                  state <= iEnable ? ST_ERASE : ST_IDLE;
                  cx    <= '0;
                  cy    <= '0;
               end else begin
                  frame_cnt <= frame_cnt - 32'd1;
               end
            end
            ST_MOVE: begin
               if (iMode[1]) begin
                  pos_x <= next_x;
                  dir_x <= next_dir_x;
               end
               if (iMode[0]) begin
                  pos_y <= next_y;
                  dir_y <= next_dir_y;
               end
               state    <= ST_DRAW;
               colour_q <= iColour;
               cx       <= '0;
               cy       <= '0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bouncing_sprite.sv
// tb_bouncing_sprite: two sprite instances (unit step with a wide X range, and
// step 3 with X_MAX one pixel past the start) run the same directed/random
// frame sequence against a frame-level position model.
module tb_bouncing_sprite;

   localparam int W    = 4;
   localparam int H    = 2;
   localparam int FT   = 8;
   localparam int NPIX = W * H;
   localparam int XS   = 72;
   localparam int YS   = 80;
   localparam int YLO  = 68;
   localparam int YHI  = 70;
   localparam int STEPS [2] = '{1, 3};
   localparam int XHI   [2] = '{145, 73};

   logic       clk = 1'b0;
   logic       iResetn;
   logic       iEnable;
   logic [1:0] iMode;
   logic [2:0] iColour;
   logic [7:0] ox    [2];
   logic [6:0] oy    [2];
   logic [2:0] ocol  [2];
   logic       plot  [2];
   logic       fdone [2];

   int vectors     = 0;
   int miscompares = 0;

   int px [2];
   int py [2];
   int dx [2];
   int dy [2];

   logic [2:0] cur_col;
   logic [1:0] mode;

   always #5 clk = ~clk;

   bouncing_sprite #(
      .SPRITE_W(W), .SPRITE_H(H), .X_MIN(0), .X_MAX(145), .Y_MIN(YLO), .Y_MAX(YHI),
      .X_START(XS), .Y_START(YS), .STEP(1), .FRAME_TICKS(FT), .BG_COLOUR(3'd0)
   ) u_dut_a (
      .iClock(clk), .iResetn(iResetn), .iEnable(iEnable), .iMode(iMode), .iColour(iColour),
      .oX(ox[0]), .oY(oy[0]), .oColour(ocol[0]), .oPlot(plot[0]), .oFrameDone(fdone[0])
   );

   bouncing_sprite #(
      .SPRITE_W(W), .SPRITE_H(H), .X_MIN(0), .X_MAX(XS + 1), .Y_MIN(YLO), .Y_MAX(YHI),
      .X_START(XS), .Y_START(YS), .STEP(3), .FRAME_TICKS(FT), .BG_COLOUR(3'd0)
   ) u_dut_b (
      .iClock(clk), .iResetn(iResetn), .iEnable(iEnable), .iMode(iMode), .iColour(iColour),
      .oX(ox[1]), .oY(oy[1]), .oColour(ocol[1]), .oPlot(plot[1]), .oFrameDone(fdone[1])
   );

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s dut%0d: observed %0d expected %0d", tag, k, obs, exp);
      end
   endtask

   function automatic void bounce(input int p, input int d, input int lo, input int hi,
                                  input int st, output int np, output int nd);
      np = p;
      nd = d;
      if (d == 0) begin
         if (p + st > hi) begin np = hi; nd = 1; end
         else np = p + st;
      end else begin
         if (p - st < lo) begin np = lo; nd = 0; end
         else np = p - st;
      end
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         px[k] = XS; py[k] = YS; dx[k] = 0; dy[k] = 0;
      end
   endtask

   task automatic model_move(input logic [1:0] m);
      int np, nd;
      for (int k = 0; k < 2; k++) begin
         if (m[1]) begin
            bounce(px[k], dx[k], 0, XHI[k], STEPS[k], np, nd);
            px[k] = np; dx[k] = nd;
         end
         if (m[0]) begin
            bounce(py[k], dy[k], YLO, YHI, STEPS[k], np, nd);
            py[k] = np; dy[k] = nd;
         end
      end
   endtask

   task automatic check_reset_outputs();
      for (int k = 0; k < 2; k++) begin
         chk("rst_x", k, 32'(ox[k]), 32'd0);
         chk("rst_y", k, 32'(oy[k]), 32'd0);
         chk("rst_colour", k, 32'(ocol[k]), 32'd0);
         chk("rst_plot", k, 32'(plot[k]), 32'd0);
         chk("rst_fdone", k, 32'(fdone[k]), 32'd0);
      end
   endtask

   task automatic check_zero(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            chk("plot_low", k, 32'(plot[k]), 32'd0);
            chk("fdone_low", k, 32'(fdone[k]), 32'd0);
         end
      end
   endtask

   // One full scan; optionally drop iEnable or pulse reset after pixel index.
   task automatic check_scan(input bit is_draw, input logic [2:0] col,
                             input int drop_at, input int rst_at);
      int idx;
      idx = 0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
               chk("plot", k, 32'(plot[k]), 32'd1);
               chk("pix_x", k, 32'(ox[k]), 32'(px[k] + c));
               chk("pix_y", k, 32'(oy[k]), 32'(py[k] + r));
               chk("colour", k, 32'(ocol[k]), 32'(col));
               chk("fdone", k, 32'(fdone[k]), 32'(is_draw && (idx == NPIX - 1)));
            end
            if (idx == drop_at) iEnable = 1'b0;
            if (idx == rst_at) begin
               iResetn = 1'b0;
               iEnable = 1'b0;
               #1;
               check_reset_outputs();
               model_reset();
               return;
            end
            idx++;
         end
      end
   endtask

   initial begin
      iResetn = 1'b1;
      iEnable = 1'b0;
      iMode   = 2'b00;
      iColour = 3'd0;
      model_reset();
      #1 iResetn = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs();
      iResetn = 1'b1;
      check_zero(4);

      // First frame: colour 5 at the start position, then bouncing frames.
      iMode   = 2'b01;
      cur_col = 3'd5;
      iColour = cur_col;
      iEnable = 1'b1;
      check_zero(1);
      for (int f = 0; f < 20; f++) begin
         iColour = 3'($urandom_range(0, 7));
         iMode   = 2'($urandom_range(0, 3));
         check_scan(1'b1, cur_col, -1, -1);
         if (f < 6)       mode = 2'b01;
         else if (f < 11) mode = 2'b11;
         else             mode = 2'($urandom_range(0, 3));
         cur_col = 3'($urandom_range(0, 7));
         iMode   = mode;
         iColour = cur_col;
         check_zero(FT);
         check_scan(1'b0, 3'd0, -1, -1);
         model_move(mode);
         check_zero(1);
      end

      // iEnable dropped mid-erase: erase, move and draw still complete.
      check_scan(1'b1, cur_col, -1, -1);
      iMode   = 2'b11;
      cur_col = 3'd3;
      iColour = cur_col;
      check_zero(FT);
      check_scan(1'b0, 3'd0, 3, -1);
      model_move(2'b11);
      check_zero(1);
      check_scan(1'b1, cur_col, -1, -1);
      check_zero(FT + 20);

      // Re-enable from idle: redraw at the same position.
      cur_col = 3'd2;
      iColour = cur_col;
      iEnable = 1'b1;
      check_zero(1);
      check_scan(1'b1, cur_col, -1, -1);
      check_zero(FT);
      check_scan(1'b0, 3'd0, -1, -1);
      model_move(2'b11);
      check_zero(1);

      // Reset pulse mid-draw, then idle until iEnable returns.
      check_scan(1'b1, cur_col, -1, 2);
      @(negedge clk);
      check_reset_outputs();
      iResetn = 1'b1;
      check_zero(6);
      cur_col = 3'd6;
      iColour = cur_col;
      iEnable = 1'b1;
      check_zero(1);
      check_scan(1'b1, cur_col, -1, -1);
      iEnable = 1'b0;
      check_zero(FT + 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
